// File: rtl/branch_predictor_pkg.sv
// branch_predictor_pkg: shared field-slicing constants, counter encodings and helpers for the BTB.
package branch_predictor_pkg;
  localparam int IDX_LO = 2;
  function automatic int tag_lo(input int index_w);
    return index_w + IDX_LO;
  endfunction
  function automatic int weak_t(input int cnt_w);
    return 1 << (cnt_w - 1);
  endfunction
  function automatic int weak_nt(input int cnt_w);
    return (1 << (cnt_w - 1)) - 1;
  endfunction
endpackage

// File: rtl/branch_predictor_if.sv
// branch_predictor_if: lookup/update/perf bundle between the pipeline (master) and the predictor (slave).
interface branch_predictor_if #(parameter int XLEN = 32, parameter int PERF_W = 16);
  logic [XLEN-1:0] lookup_pc;
  logic predict_taken;
  logic [XLEN-1:0] predict_target;
  logic update_valid;
  logic [XLEN-1:0] update_pc;
  logic update_taken;
  logic [XLEN-1:0] update_target;
  logic update_pred_taken;
  logic [XLEN-1:0] update_pred_target;
  logic update_mispredict;
  logic flush_all;
  logic [PERF_W-1:0] branch_count;
  logic [PERF_W-1:0] mispredict_count;
  modport master(
    output lookup_pc, update_valid, update_pc, update_taken, update_target,
           update_pred_taken, update_pred_target, flush_all,
    input  predict_taken, predict_target, update_mispredict, branch_count, mispredict_count
  );
  modport slave(
    input  lookup_pc, update_valid, update_pc, update_taken, update_target,
           update_pred_taken, update_pred_target, flush_all,
    output predict_taken, predict_target, update_mispredict, branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predictor_sat_counter.sv
// bp_sat_counter: W-bit up/down saturating counter with parallel load; load has priority.
module bp_sat_counter #(
  parameter int W = 2,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic [W-1:0] load_val_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? load_val_i :
                      (inc_i && !(&cnt_q)) ? cnt_q + W'(1) :
                      (dec_i && |cnt_q) ? cnt_q - W'(1) : cnt_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt_q <= RST_VAL;
    else cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with per-entry saturating direction counters,
// combinational lookup, EX-stage update, mispredict detect and saturating perf counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int INDEX_W = 4,
  parameter int TAG_W = 8,
  parameter int CNT_W = 2,
  parameter int PERF_W = 16
) (
  input logic clk,
  input logic reset,
  branch_predictor_if.slave bp
);
  localparam int N = 1 << INDEX_W;
  localparam int TL = tag_lo(INDEX_W);
  localparam logic [CNT_W-1:0] WEAK_T = CNT_W'(weak_t(CNT_W));
  localparam logic [CNT_W-1:0] WEAK_NT = CNT_W'(weak_nt(CNT_W));
  typedef struct packed {
    logic mode;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0] target;
  } entry_t;
  entry_t entry_q [N];
  logic [N-1:0] valid_q;
  logic [N-1:0][CNT_W-1:0] cnt;
  logic [INDEX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  entry_t l_e, u_e;
  logic l_hit, u_hit, upd;
  logic unused_pc_bits;
  assign l_idx = bp.lookup_pc[TL-1:IDX_LO];
  assign l_tag = bp.lookup_pc[TL+TAG_W-1:TL];
  assign u_idx = bp.update_pc[TL-1:IDX_LO];
  assign u_tag = bp.update_pc[TL+TAG_W-1:TL];
  assign l_e = entry_q[l_idx];
  assign u_e = entry_q[u_idx];
  assign l_hit = valid_q[l_idx] && l_e.tag == l_tag && l_e.mode == bp.lookup_pc[XLEN-1];
  assign u_hit = valid_q[u_idx] && u_e.tag == u_tag && u_e.mode == bp.update_pc[XLEN-1];
  // flush takes priority over any same-cycle table write
  assign upd = bp.update_valid && !bp.flush_all;
  assign unused_pc_bits = ^{bp.lookup_pc[IDX_LO-1:0], bp.lookup_pc[XLEN-2:TL+TAG_W],
                            bp.update_pc[IDX_LO-1:0], bp.update_pc[XLEN-2:TL+TAG_W]};
  assign bp.predict_taken = l_hit && cnt[l_idx][CNT_W-1];
  assign bp.predict_target = bp.predict_taken ? l_e.target : bp.lookup_pc + XLEN'(4);
  assign bp.update_mispredict = bp.update_valid &&
    (bp.update_taken != bp.update_pred_taken ||
     (bp.update_taken && bp.update_target != bp.update_pred_target));
  always_ff @(posedge clk or negedge reset)
    if (!reset) valid_q <= '0;
    else if (bp.flush_all) valid_q <= '0;
    else if (upd && bp.update_taken) valid_q[u_idx] <= 1'b1;
  // tags/targets are unreset; valid_q masks stale contents
  always_ff @(posedge clk)
    if (upd && bp.update_taken) begin
      entry_q[u_idx].target <= bp.update_target;
      if (!u_hit) begin
        entry_q[u_idx].tag <= u_tag;
        entry_q[u_idx].mode <= bp.update_pc[XLEN-1];
      end
    end
  for (genvar e = 0; e < N; e++) begin : g_cnt
    logic sel;
    assign sel = upd && u_idx == INDEX_W'(e);
    bp_sat_counter #(.W(CNT_W), .RST_VAL(WEAK_NT)) u_cnt (
      .clk(clk),
      .reset(reset),
      .load_i(sel && !u_hit && bp.update_taken),
      .load_val_i(WEAK_T),
      .inc_i(sel && u_hit && bp.update_taken),
      .dec_i(sel && u_hit && !bp.update_taken),
      .cnt_o(cnt[e])
    );
  end
  bp_sat_counter #(.W(PERF_W)) u_branch_cnt (
    .clk(clk),
    .reset(reset),
    .load_i(1'b0),
    .load_val_i('0),
    .inc_i(bp.update_valid),
    .dec_i(1'b0),
    .cnt_o(bp.branch_count)
  );
  bp_sat_counter #(.W(PERF_W)) u_mispredict_cnt (
    .clk(clk),
    .reset(reset),
    .load_i(1'b0),
    .load_val_i('0),
    .inc_i(bp.update_mispredict),
    .dec_i(1'b0),
    .cnt_o(bp.mispredict_count)
  );
endmodule
